req_ack_sequencer: RTL and testbench
====================================

Name: req_ack_sequencer

Overview:
- Master-side controller for a single-pulse req/ack handshake with fixed acknowledge latency.
- On a start command it issues a one-cycle req pulse, then checks that ack rises exactly ACK_DELAY cycles later.
- On a miss it retries up to MAX_RETRY times, then reports done or an error code.
- Keeps running pass/fail counters, so directed benches and the constant-delay assertion checks can be driven from one sequencer.

Parameters:
- ACK_DELAY, 3: required posedges from the first posedge sampling req=1 to the posedge sampling the ack rise; legal range 1..15.
- MAX_RETRY, 2: re-issues allowed after a failed attempt; 0 means a single attempt.
- GAP_CYCLES, 2: minimum cycles with req=0 between consecutive req pulses; legal range >=1.
- CNT_W, 8: width of the pass/fail counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command; ignored while busy=1.
- ack  in  1  acknowledge from the responder; sampled on posedge.
- req  out  1  request pulse; registered.
- busy  out  1  high from the cycle after start is accepted until done or err pulses.
- done  out  1  one-cycle pulse: handshake succeeded.
- err  out  1  one-cycle pulse: handshake abandoned.
- err_code  out  2  0=none, 1=early ack, 2=no ack, 3=ack stuck high; held until next start.
- retry_cnt  out  2  retries used by the current or last transaction.
- pass_cnt  out  CNT_W  successful transactions; saturates.
- fail_cnt  out  CNT_W  failed attempts, including retried ones; saturates.

Behaviour:
- Reset (async, any state): state=IDLE; req, busy, done, err=0; err_code=0; retry_cnt=0; pass_cnt, fail_cnt=0; ack_q=0. req drops immediately even mid-pulse.
- Edge detect: ack_q registers ack. rise = ack & ~ack_q, evaluated at each posedge.
- Cycle counter: wcnt, 4 bits, cleared on entry to REQ.
- IDLE:
  - start=1 → REQ; busy=1 next cycle; retry_cnt=0; err_code=0.
  - Latency start→req high is 1 cycle.
- REQ:
  - req=1 for exactly one cycle; the posedge at its end is P0.
  - If ack=1 at P0: stuck error (code 3), no retry → ERR.
  - Otherwise wcnt=1 → WAIT.
- WAIT (req=0): at each posedge Pk (k=wcnt):
  - rise and k<ACK_DELAY: early (code 1), failed attempt.
  - rise and k==ACK_DELAY: success → DONE.
  - no rise and k==ACK_DELAY: no-ack (code 2), failed attempt.
  - otherwise wcnt++.
- Failed attempt handling:
  - fail_cnt++.
  - If retry_cnt<MAX_RETRY: retry_cnt++ → GAP.
  - Else → ERR.
- GAP: req=0 for GAP_CYCLES cycles, then → REQ. If ack=1 on the last GAP posedge → stuck error (code 3) → ERR.
- DONE: done=1 for one cycle; pass_cnt++; busy=0 → IDLE.
- ERR: err=1 for one cycle; busy=0 → IDLE; err_code keeps the cause of the final attempt.
- Simultaneous events:
  - start in DONE/ERR is ignored.
  - start in the same cycle as a reset release is ignored.
  - ack activity after the decision posedge is ignored until the next REQ.
- Counters saturate at all-ones; no wrap.
- Minimum transaction time: 1 + 1 + ACK_DELAY + 1 cycles from start to done; 6 with defaults.

Test Plan:
1. Nominal: start at cycle 0; ack rises at posedge P0+3 (ACK_DELAY=3) → done pulses once; pass_cnt=1; retry_cnt=0; err_code=0.
2. Early ack: ack rises at P0+1 on every attempt, MAX_RETRY=2 → three req pulses, each separated by ≥2 low cycles; fail_cnt=3; err pulses; err_code=1; retry_cnt=2.
3. Late then good: ack rises at P0+4 on the first attempt (miss, code 2 transient), then at P0+3 on the retry → done; pass_cnt=1; fail_cnt=1; retry_cnt=1; err_code=2 latched but done asserted.
4. Stuck ack: ack held 1 before start → err after the first REQ; err_code=3; no retry; fail_cnt unchanged.
5. Reset mid-WAIT: assert rst at P0+2 asynchronously → req, busy=0 within the same cycle; all counters=0; a subsequent start with good ack yields done and pass_cnt=1.
6. Start while busy: pulse start at P0+1 → ignored, only one req pulse; start 10 times back-to-back with good ack → pass_cnt=10; start ignored during DONE cycles.

Source files
------------

// File: rtl/req_ack_sequencer_if.sv
// Handshake bundle for req_ack_sequencer: command, responder ack, and status.
// master: sequencer side (drives req and status); slave: command/responder side.
interface req_ack_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             ack;
    logic             req;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [1:0]       retry_cnt;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        input  start, ack,
        output req, busy, done, err, err_code, retry_cnt, pass_cnt, fail_cnt
    );

    modport slave (
        output start, ack,
        input  req, busy, done, err, err_code, retry_cnt, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/req_ack_sequencer.sv
// Single-pulse req/ack master: issues req, expects ack rise ACK_DELAY edges later.
// Ports: clk, rst (async high), bus (master modport: start/ack in, req/status out).
module req_ack_sequencer #(
    parameter int ACK_DELAY  = 3,
    parameter int MAX_RETRY  = 2,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    req_ack_sequencer_if.master bus
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [3:0]    DLY   = 4'(ACK_DELAY);
    localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GONE  = GW'(1);
    localparam logic [1:0]    E_EARLY = 2'd1;
    localparam logic [1:0]    E_NOACK = 2'd2;
    localparam logic [1:0]    E_STUCK = 2'd3;
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [1:0]       rty_q, rty_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             ack_q;
    // Low for the first edge after reset release so a start there is dropped.
    logic             arm_q;
    logic             rise;
    logic             can_retry;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CONE;
    endfunction

    assign rise      = bus.ack & ~ack_q;
    assign can_retry = {30'd0, rty_q} < 32'(MAX_RETRY);

    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        rty_d   = rty_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && arm_q) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    rty_d   = 2'd0;
                    code_d  = 2'd0;
                    wcnt_d  = 4'd0;
                end
            end
            S_REQ: begin
                // ack already high while req is sampled: responder is stuck.
                if (bus.ack) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    code_d  = E_STUCK;
                end else begin
                    state_d = S_WAIT;
                    wcnt_d  = 4'd1;
                end
            end
            S_WAIT: begin
                if (rise && wcnt_q == DLY) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = sat_inc(pass_q);
                end else if (rise || wcnt_q == DLY) begin
                    code_d = rise ? E_EARLY : E_NOACK;
                    fail_d = sat_inc(fail_q);
                    if (can_retry) begin
                        state_d = S_GAP;
                        rty_d   = rty_q + 2'd1;
                        gcnt_d  = '0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_GAP: begin
                if (gcnt_q == GLAST) begin
                    if (bus.ack) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        code_d  = E_STUCK;
                    end else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        wcnt_d  = 4'd0;
                    end
                end else begin
                    gcnt_d = gcnt_q + GONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            rty_q   <= 2'd0;
            pass_q  <= '0;
            fail_q  <= '0;
            wcnt_q  <= 4'd0;
            gcnt_q  <= '0;
            ack_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            rty_q   <= rty_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            ack_q   <= bus.ack;
            arm_q   <= 1'b1;
        end
    end

    assign bus.req       = req_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.retry_cnt = rty_q;
    assign bus.pass_cnt  = pass_q;
    assign bus.fail_cnt  = fail_q;
endmodule

// File: tb/tb_req_ack_sequencer.sv
// Bench for req_ack_sequencer: reactive responder, timestamp-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_req_ack_sequencer;
    localparam int ACK_DELAY  = 3;
    localparam int MAX_RETRY  = 2;
    localparam int GAP_CYCLES = 2;
    localparam int CNT_W      = 4;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit start_s = 1'b0;
    bit ack_s   = 1'b0;

    req_ack_sequencer_if #(.CNT_W(CNT_W)) bus ();

    assign bus.start = start_s;
    assign bus.ack   = ack_s;

    req_ack_sequencer #(
        .ACK_DELAY (ACK_DELAY),
        .MAX_RETRY (MAX_RETRY),
        .GAP_CYCLES(GAP_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    // Responder: pulses ack for one cycle, rdly edges after the edge that
    // samples req (rdly=0 lands on that edge, -1 means never).
    bit hold_ack = 1'b0;
    bit use_plan = 1'b1;
    int plan [3] = '{3, 3, 3};
    int att_i = 0;
    int rk    = -1;
    int rdly  = -1;

    always @(negedge clk) begin
        bit spur;
        spur = 1'b0;
        if (bus.req === 1'b1) begin
            rk = 0;
            if (use_plan) begin
                rdly = plan[att_i];
                if (att_i < 2) att_i++;
            end else begin
                case ($urandom_range(0, 9))
                    0: rdly = 0;
                    1: rdly = -1;
                    2: rdly = 1;
                    3: rdly = 2;
                    4: rdly = 4;
                    5: rdly = 5;
                    default: rdly = 3;
                endcase
            end
        end else if (rk >= 0 && rk < 1000) begin
            rk++;
        end
        if (!use_plan) spur = ($urandom_range(0, 59) == 0);
        ack_s = hold_ack || spur || (rk >= 0 && rk == rdly);
    end

    // Reference model: time-stamped attempts. mp0 is the edge index that
    // samples req; the verdict is the first ack rise at mp0+k, k<=ACK_DELAY.
    int mcyc = 0;
    int mp0  = 0;
    int mgap = 0;
    int mph  = 0;
    bit marmed = 1'b0;
    bit mack_prev = 1'b0;
    bit m_req = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int m_code = 0, m_rty = 0, m_pass = 0, m_fail = 0;

    task automatic m_abandon(input int code);
        m_code = code;
        m_err  = 1'b1;
        m_busy = 1'b0;
        mph    = 3;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcyc = 0; mph = 0; marmed = 1'b0; mack_prev = 1'b0;
            m_req = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_code = 0; m_rty = 0; m_pass = 0; m_fail = 0;
        end else begin : mstep
            int k;
            bit a, r;
            mcyc++;
            a = ack_s;
            r = a && !mack_prev;
            mack_prev = a;
            m_req = 1'b0; m_done = 1'b0; m_err = 1'b0;
            case (mph)
                0: if (start_s && marmed) begin
                    mp0 = mcyc + 1; mph = 1;
                    m_req = 1'b1; m_busy = 1'b1; m_rty = 0; m_code = 0;
                end
                1: if (mcyc == mp0) begin
                    if (a) m_abandon(3);
                end else begin
                    k = mcyc - mp0;
                    if (r && k == ACK_DELAY) begin
                        m_done = 1'b1; m_busy = 1'b0; mph = 3;
                        if (m_pass < CMAX) m_pass++;
                    end else if (r || k == ACK_DELAY) begin
                        if (m_fail < CMAX) m_fail++;
                        if (m_rty < MAX_RETRY) begin
                            m_code = r ? 1 : 2;
                            m_rty++;
                            mgap = mcyc + GAP_CYCLES;
                            mph = 2;
                        end else begin
                            m_abandon(r ? 1 : 2);
                        end
                    end
                end
                2: if (mcyc == mgap) begin
                    if (a) m_abandon(3);
                    else begin
                        mp0 = mcyc + 1; mph = 1; m_req = 1'b1;
                    end
                end
                default: mph = 0;
            endcase
            marmed = 1'b1;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", bus.req, m_req);
            chk("busy", bus.busy, m_busy);
            chk("done", bus.done, m_done);
            chk("err", bus.err, m_err);
            chk("err_code", bus.err_code, m_code);
            chk("retry_cnt", bus.retry_cnt, m_rty);
            chk("pass_cnt", bus.pass_cnt, m_pass);
            chk("fail_cnt", bus.fail_cnt, m_fail);
        end
    end

    // Pulse monitor for directed checks.
    int nreq = 0, ndone = 0, nerr = 0, lowrun = 0, mingap = 99;
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (bus.req === 1'b1) begin
            if (seen && lowrun < mingap) mingap = lowrun;
            lowrun = 0; seen = 1'b1; nreq++;
        end else begin
            lowrun++;
        end
        if (bus.done === 1'b1) ndone++;
        if (bus.err === 1'b1) nerr++;
    end

    task automatic clr_mon();
        nreq = 0; ndone = 0; nerr = 0; lowrun = 0; mingap = 99; seen = 1'b0;
    endtask

    task automatic plan_set(input int a, input int b, input int c);
        plan[0] = a; plan[1] = b; plan[2] = c;
        att_i = 0; use_plan = 1'b1; rk = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int first_req = 0;
    int lat = 0;

    task automatic wait_fin();
        bit fin;
        fin = 1'b0;
        lat = 0;
        while (!fin && lat < 80) begin
            if (bus.done === 1'b1 || bus.err === 1'b1) fin = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        n_assert++;
        if (!fin) begin
            n_fail++;
            $display("FAIL txn_timeout: got no done/err, required one within 80");
        end
        @(negedge clk);
    endtask

    task automatic txn();
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        first_req = bus.req;
        wait_fin();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_req", bus.req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pass", bus.pass_cnt, 0);
        chk("rst_code", bus.err_code, 0);
        rst = 1'b0;

        // 1: nominal
        plan_set(3, 3, 3); clr_mon(); txn();
        chk("nom_req_lat", first_req, 1);
        chk("nom_done_lat", lat, 4);
        chk("nom_ndone", ndone, 1);
        chk("nom_nreq", nreq, 1);
        chk("nom_pass", bus.pass_cnt, 1);
        chk("nom_code", bus.err_code, 0);
        chk("nom_rty", bus.retry_cnt, 0);

        // 2: early ack on every attempt
        do_reset(); plan_set(1, 1, 1); clr_mon(); txn();
        chk("early_nreq", nreq, 3);
        chk("early_nerr", nerr, 1);
        chk("early_ndone", ndone, 0);
        chk("early_gap", mingap, 3);
        chk("early_fail", bus.fail_cnt, 3);
        chk("early_code", bus.err_code, 1);
        chk("early_rty", bus.retry_cnt, 2);

        // 3: late then good
        do_reset(); plan_set(4, 3, 3); clr_mon(); txn();
        chk("late_ndone", ndone, 1);
        chk("late_nreq", nreq, 2);
        chk("late_pass", bus.pass_cnt, 1);
        chk("late_fail", bus.fail_cnt, 1);
        chk("late_rty", bus.retry_cnt, 1);
        chk("late_code", bus.err_code, 2);

        // 4: ack stuck high
        do_reset(); plan_set(-1, -1, -1); hold_ack = 1'b1;
        repeat (2) @(negedge clk);
        clr_mon(); txn();
        chk("stuck_nerr", nerr, 1);
        chk("stuck_nreq", nreq, 1);
        chk("stuck_code", bus.err_code, 3);
        chk("stuck_fail", bus.fail_cnt, 0);
        chk("stuck_rty", bus.retry_cnt, 0);
        hold_ack = 1'b0;
        repeat (2) @(negedge clk);

        // 5: async reset mid-WAIT and mid-req
        do_reset(); plan_set(3, 3, 3); txn();
        chk("r5_pass_pre", bus.pass_cnt, 1);
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("r5_req", bus.req, 0);
        chk("r5_busy", bus.busy, 0);
        chk("r5_pass", bus.pass_cnt, 0);
        chk("r5_fail", bus.fail_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        start_s = 1'b1; rst = 1'b0;
        @(negedge clk);
        start_s = 1'b0;
        chk("r5_release_start", bus.req, 0);
        plan_set(3, 3, 3); clr_mon(); txn();
        chk("r5_ndone", ndone, 1);
        chk("r5_pass_post", bus.pass_cnt, 1);
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        #1 rst = 1'b1;
        #1 chk("r5_mid_req", bus.req, 0);
        @(negedge clk); rst = 1'b0;

        // 6: start while busy, back-to-back starts, saturation
        do_reset(); plan_set(3, 3, 3); clr_mon();
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        wait_fin();
        repeat (3) @(negedge clk);
        chk("busy_nreq", nreq, 1);
        chk("busy_pass", bus.pass_cnt, 1);

        do_reset(); plan_set(3, 3, 3); clr_mon();
        @(negedge clk); start_s = 1'b1;
        for (int i = 0; i < 300 && ndone < 10; i++) @(negedge clk);
        start_s = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_ndone", ndone, 10);
        chk("b2b_nreq", nreq, 10);
        chk("b2b_pass", bus.pass_cnt, 10);

        do_reset(); plan_set(3, 3, 3); clr_mon();
        @(negedge clk); start_s = 1'b1;
        for (int i = 0; i < 400 && ndone < 17; i++) @(negedge clk);
        start_s = 1'b0;
        repeat (8) @(negedge clk);
        chk("sat_ndone", ndone, 17);
        chk("sat_pass", bus.pass_cnt, CMAX);

        // Random phase against the model
        do_reset(); use_plan = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start_s = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 799) == 0);
        end
        rst = 1'b0; start_s = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
